// File: rtl/sc_level_pkg.sv
// Shared types and sizing helpers for the RoadFighter level sequencer.
package sc_level_pkg;

    typedef enum logic [2:0] {
        MESSAGE   = 3'd0,
        PLAY      = 3'd1,
        CRASH     = 3'd2,
        LEVEL_END = 3'd3,
        END       = 3'd4
    } levelState_t;

    localparam int unsigned TARGETS_MAX_W = 256;

    function automatic int unsigned levelWidth(input int unsigned numLevels);
        return (numLevels > 1) ? $clog2(numLevels) : 1;
    endfunction

    function automatic int unsigned timerWidth(input int unsigned msgCycles,
                                               input int unsigned crashCycles);
        int unsigned longest;
        longest = (msgCycles > crashCycles) ? msgCycles : crashCycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    // Level i's target sits at [i*width +: width] of the packed vector.
    function automatic logic [31:0] targetSlice(input logic [TARGETS_MAX_W-1:0] targets,
                                                input int unsigned level,
                                                input int unsigned width);
        return 32'(targets >> (level * width)) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/sc_cycle_timer.sv
// Loadable down-counter that parks at zero; shared by the message and crash phases.
module sc_cycle_timer #(
    parameter int unsigned       WIDTH       = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic              clock50,
    input  logic              resetInLow,
    input  logic              load,
    input  logic [WIDTH-1:0]  loadValue,
    input  logic              countEnable,
    output logic              atZero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock50) begin
        if (!resetInLow) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= loadValue;
        end else if (countEnable && !atZero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign atZero = (count == '0);

endmodule

// File: rtl/sc_level_sequencer.sv
// Game-level sequencer: owns level/progress counters and drives active-low status strobes.
//   state     | meaning
//   MESSAGE   | "LEVEL n" banner shown for MSG_CYCLES clocks
//   PLAY      | ticks advance progress; crash or target reached leaves
//   CRASH     | freeze for CRASH_CYCLES clocks, progress held
//   LEVEL_END | one-cycle level-complete pulse
//   END       | game over, waits for restart
module sc_level_sequencer
    import sc_level_pkg::*;
#(
    parameter int unsigned                         NUM_LEVELS    = 4,
    parameter int unsigned                         PROGRESS_W    = 5,
    parameter logic [NUM_LEVELS*PROGRESS_W-1:0]    LEVEL_TARGETS = {5'd30, 5'd21, 5'd17, 5'd17},
    parameter int unsigned                         MSG_CYCLES    = 50_000_000,
    parameter int unsigned                         CRASH_CYCLES  = 25_000_000,
    localparam int unsigned                        LEVEL_W       = levelWidth(NUM_LEVELS),
    localparam int unsigned                        TIMER_W       = timerWidth(MSG_CYCLES, CRASH_CYCLES)
) (
    input  logic                   SC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic                   SC_LEVEL_SEQUENCER_RESET_InLow,
    input  logic                   SC_LEVEL_SEQUENCER_Tick_InLow,
    input  logic                   SC_LEVEL_SEQUENCER_Crash_InLow,
    input  logic                   SC_LEVEL_SEQUENCER_Restart_InLow,
    output logic [LEVEL_W-1:0]     SC_LEVEL_SEQUENCER_CurrentLevel_Out,
    output logic [PROGRESS_W-1:0]  SC_LEVEL_SEQUENCER_Progress_Out,
    output logic                   SC_LEVEL_SEQUENCER_Message_OutLow,
    output logic                   SC_LEVEL_SEQUENCER_Freeze_OutLow,
    output logic                   SC_LEVEL_SEQUENCER_LevelEnd_OutLow,
    output logic                   SC_LEVEL_SEQUENCER_GameEnd_OutLow
);

    localparam logic [TARGETS_MAX_W-1:0] TARGETS_PADDED = TARGETS_MAX_W'(LEVEL_TARGETS);
    localparam logic [TIMER_W-1:0]       MSG_LOAD       = TIMER_W'(MSG_CYCLES - 1);
    localparam logic [TIMER_W-1:0]       CRASH_LOAD     = TIMER_W'(CRASH_CYCLES - 1);
    localparam logic [LEVEL_W-1:0]       LAST_LEVEL     = LEVEL_W'(NUM_LEVELS - 1);

    levelState_t              state;
    logic [LEVEL_W-1:0]       level;
    logic [PROGRESS_W-1:0]    progress;
    logic [PROGRESS_W-1:0]    levelTarget;
    logic                     levelDone;
    logic                     lastLevel;
    logic                     timerLoad;
    logic [TIMER_W-1:0]       timerLoadValue;
    logic                     timerEnable;
    logic                     timerZero;
    logic                     messageLow;
    logic                     freezeLow;
    logic                     levelEndLow;
    logic                     gameEndLow;

    assign levelTarget = PROGRESS_W'(targetSlice(TARGETS_PADDED, 32'(level), PROGRESS_W));
    assign levelDone   = (progress == levelTarget);
    assign lastLevel   = (level == LAST_LEVEL);
    assign timerEnable = (state == MESSAGE) || (state == CRASH);

    // Timer reloads mirror the FSM transitions that enter MESSAGE or CRASH.
    always_comb begin
        timerLoad      = 1'b0;
        timerLoadValue = MSG_LOAD;
        case (state)
            PLAY: begin
                if (!levelDone && !SC_LEVEL_SEQUENCER_Crash_InLow) begin
                    timerLoad      = 1'b1;
                    timerLoadValue = CRASH_LOAD;
                end
            end
            LEVEL_END: timerLoad = !lastLevel;
            END:       timerLoad = !SC_LEVEL_SEQUENCER_Restart_InLow;
            MESSAGE, CRASH: ;
            default:   timerLoad = 1'b1;
        endcase
    end

    sc_cycle_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (MSG_LOAD)
    ) phaseTimer (
        .clock50     (SC_LEVEL_SEQUENCER_CLOCK_50),
        .resetInLow  (SC_LEVEL_SEQUENCER_RESET_InLow),
        .load        (timerLoad),
        .loadValue   (timerLoadValue),
        .countEnable (timerEnable),
        .atZero      (timerZero)
    );

    // Strobes are registered alongside the state so they decode the state being entered.
    always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50) begin
        if (!SC_LEVEL_SEQUENCER_RESET_InLow) begin
            state       <= MESSAGE;
            level       <= '0;
            progress    <= '0;
            messageLow  <= 1'b0;
            freezeLow   <= 1'b1;
            levelEndLow <= 1'b1;
            gameEndLow  <= 1'b1;
        end else begin
            case (state)
                MESSAGE: begin
                    if (timerZero) begin
                        state      <= PLAY;
                        messageLow <= 1'b1;
                    end
                end
                PLAY: begin
                    if (levelDone) begin
                        state       <= LEVEL_END;
                        levelEndLow <= 1'b0;
                    end else if (!SC_LEVEL_SEQUENCER_Crash_InLow) begin
                        state     <= CRASH;
                        freezeLow <= 1'b0;
                    end else if (!SC_LEVEL_SEQUENCER_Tick_InLow) begin
                        progress <= progress + PROGRESS_W'(1);
                    end
                end
                CRASH: begin
                    if (timerZero) begin
                        state     <= PLAY;
                        freezeLow <= 1'b1;
                    end
                end
                LEVEL_END: begin
                    levelEndLow <= 1'b1;
                    if (lastLevel) begin
                        state      <= END;
                        gameEndLow <= 1'b0;
                    end else begin
                        state      <= MESSAGE;
                        level      <= level + LEVEL_W'(1);
                        progress   <= '0;
                        messageLow <= 1'b0;
                    end
                end
                END: begin
                    if (!SC_LEVEL_SEQUENCER_Restart_InLow) begin
                        state      <= MESSAGE;
                        level      <= '0;
                        progress   <= '0;
                        messageLow <= 1'b0;
                        gameEndLow <= 1'b1;
                    end
                end
                default: begin
                    state       <= MESSAGE;
                    level       <= '0;
                    progress    <= '0;
                    messageLow  <= 1'b0;
                    freezeLow   <= 1'b1;
                    levelEndLow <= 1'b1;
                    gameEndLow  <= 1'b1;
                end
            endcase
        end
    end

    assign SC_LEVEL_SEQUENCER_CurrentLevel_Out = level;
    assign SC_LEVEL_SEQUENCER_Progress_Out     = progress;
    assign SC_LEVEL_SEQUENCER_Message_OutLow    = messageLow;
    assign SC_LEVEL_SEQUENCER_Freeze_OutLow     = freezeLow;
    assign SC_LEVEL_SEQUENCER_LevelEnd_OutLow   = levelEndLow;
    assign SC_LEVEL_SEQUENCER_GameEnd_OutLow    = gameEndLow;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench for sc_level_sequencer with two short levels and short timed phases.
module tb_sc_level_sequencer;

    localparam int NL      = 2;
    localparam int MSG     = 4;
    localparam int CRASHN  = 3;
    localparam int S_MSG   = 0;
    localparam int S_PLAY  = 1;
    localparam int S_CRASH = 2;
    localparam int S_LEND  = 3;
    localparam int S_END   = 4;

    logic        clock50    = 1'b0;
    logic        resetLow   = 1'b0;
    logic        tickLow    = 1'b1;
    logic        crashLow   = 1'b1;
    logic        restartLow = 1'b1;
    logic [0:0]  levelOut;
    logic [2:0]  progressOut;
    logic        messageLow;
    logic        freezeLow;
    logic        levelEndLow;
    logic        gameEndLow;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNum    = 0;
    int msgLowCnt   = 0;
    int frzLowCnt   = 0;
    int levelEndCnt = 0;
    int gameEndCnt  = 0;

    int mState = S_MSG;
    int mLevel = 0;
    int mProg  = 0;
    int mTimer = MSG - 1;
    int targets[NL] = '{2, 3};

    logic [7:0] expQ[$];

    always #5 clock50 = ~clock50;

    sc_level_sequencer #(
        .NUM_LEVELS    (2),
        .PROGRESS_W    (3),
        .LEVEL_TARGETS ({3'd3, 3'd2}),
        .MSG_CYCLES    (MSG),
        .CRASH_CYCLES  (CRASHN)
    ) dut (
        .SC_LEVEL_SEQUENCER_CLOCK_50         (clock50),
        .SC_LEVEL_SEQUENCER_RESET_InLow      (resetLow),
        .SC_LEVEL_SEQUENCER_Tick_InLow       (tickLow),
        .SC_LEVEL_SEQUENCER_Crash_InLow      (crashLow),
        .SC_LEVEL_SEQUENCER_Restart_InLow    (restartLow),
        .SC_LEVEL_SEQUENCER_CurrentLevel_Out (levelOut),
        .SC_LEVEL_SEQUENCER_Progress_Out     (progressOut),
        .SC_LEVEL_SEQUENCER_Message_OutLow   (messageLow),
        .SC_LEVEL_SEQUENCER_Freeze_OutLow    (freezeLow),
        .SC_LEVEL_SEQUENCER_LevelEnd_OutLow  (levelEndLow),
        .SC_LEVEL_SEQUENCER_GameEnd_OutLow   (gameEndLow)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic modelEdge(input logic rst, input logic tick, input logic crash, input logic restart);
        if (!rst) begin
            mState = S_MSG; mLevel = 0; mProg = 0; mTimer = MSG - 1;
        end else begin
            case (mState)
                S_MSG:   if (mTimer == 0) mState = S_PLAY; else mTimer--;
                S_PLAY: begin
                    if (mProg == targets[mLevel]) mState = S_LEND;
                    else if (!crash) begin mState = S_CRASH; mTimer = CRASHN - 1; end
                    else if (!tick) mProg++;
                end
                S_CRASH: if (mTimer == 0) mState = S_PLAY; else mTimer--;
                S_LEND: begin
                    if (mLevel == NL - 1) mState = S_END;
                    else begin mLevel++; mProg = 0; mTimer = MSG - 1; mState = S_MSG; end
                end
                default: begin
                    if (!restart) begin mLevel = 0; mProg = 0; mTimer = MSG - 1; mState = S_MSG; end
                end
            endcase
        end
    endtask

    function automatic logic [7:0] modelOutputs();
        logic [7:0] v;
        v[7]   = mLevel[0];
        v[6:4] = mProg[2:0];
        v[3]   = (mState != S_MSG);
        v[2]   = (mState != S_CRASH);
        v[1]   = (mState != S_LEND);
        v[0]   = (mState != S_END);
        return v;
    endfunction

    task automatic cycle(input logic rst, input logic tick, input logic crash, input logic restart);
        logic [7:0] got;
        logic [7:0] want;
        resetLow = rst; tickLow = tick; crashLow = crash; restartLow = restart;
        modelEdge(rst, tick, crash, restart);
        expQ.push_back(modelOutputs());
        @(posedge clock50);
        #1;
        cycleNum++;
        got  = {levelOut, progressOut, messageLow, freezeLow, levelEndLow, gameEndLow};
        want = expQ.pop_front();
        checkEq($sformatf("cycle%0d", cycleNum), 32'(got), 32'(want));
        if (!messageLow)  msgLowCnt++;
        if (!freezeLow)   frzLowCnt++;
        if (!levelEndLow) levelEndCnt++;
        if (!gameEndLow)  gameEndCnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset and first message phase
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        msgLowCnt = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checkEq("rst_msg",    32'(messageLow),  0);
        checkEq("rst_freeze", 32'(freezeLow),   1);
        checkEq("rst_lend",   32'(levelEndLow), 1);
        checkEq("rst_gend",   32'(gameEndLow),  1);
        idle(8);
        checkEq("t1_msg_len", msgLowCnt, 4);
        checkEq("t1_level",   32'(levelOut),    0);
        checkEq("t1_prog",    32'(progressOut), 0);

        // level 0: two ticks complete it
        levelEndCnt = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        checkEq("t2_prog2", 32'(progressOut), 2);
        msgLowCnt = 0;
        idle(8);
        checkEq("t2_lend_cnt", levelEndCnt, 1);
        checkEq("t2_msg_len",  msgLowCnt, 4);
        checkEq("t2_level",    32'(levelOut), 1);
        checkEq("t2_prog0",    32'(progressOut), 0);

        // crash beats tick, freeze ignores ticks and repeat crashes
        frzLowCnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        checkEq("t3_frz_len", frzLowCnt, 3);
        checkEq("t3_prog_held", 32'(progressOut), 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        checkEq("t3_prog_after", 32'(progressOut), 1);

        // restart outside END is ignored; finish level 1
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checkEq("t4_no_restart", 32'(messageLow), 1);
        levelEndCnt = 0;
        gameEndCnt  = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(4);
        checkEq("t4_lend_cnt", levelEndCnt, 1);
        checkEq("t4_gend_cnt", gameEndCnt, 3);
        checkEq("t4_prog_end", 32'(progressOut), 3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checkEq("t4_restart_lvl", 32'(levelOut), 0);
        checkEq("t4_restart_msg", 32'(messageLow), 0);

        // reach level 1, crash, then reset mid-freeze
        idle(8);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(8);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("t5_in_crash", 32'(freezeLow), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checkEq("t5_level", 32'(levelOut), 0);
        checkEq("t5_prog",  32'(progressOut), 0);
        checkEq("t5_msg",   32'(messageLow), 0);
        checkEq("t5_frz",   32'(freezeLow), 1);

        // reset released between edges: nothing moves until the next edge
        #3 resetLow = 1'b1;
        #2;
        checkEq("t6_rel_msg",   32'(messageLow), 0);
        checkEq("t6_rel_level", 32'(levelOut), 0);
        msgLowCnt = 0;
        idle(6);
        checkEq("t6_msg_rest", msgLowCnt, 3);

        // reset asserted between edges: state holds until the edge
        resetLow = 1'b0;
        #3;
        checkEq("t6_assert_hold", 32'(messageLow), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checkEq("t6_assert_msg", 32'(messageLow), 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
